// File: rtl/arb_rr_lock.sv
// arb_rr_lock: round-robin arbiter with packet locking; define ARB_LOCK_TIMEOUT_EN to add a forced-release stall timeout
module arb_rr_lock #(
  parameter int N = 5,
  parameter int IDW = (N > 1) ? $clog2(N) : 1,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   tail,
  input  logic           ready,
  output logic [N-1:0]   grt,
  output logic [IDW-1:0] grt_id,
  output logic           busy,
  output logic           timeout_err
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, owner_q, owner_d, win, idx, gid;
  logic found, gv, fire, tmo;

  function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + IDW'(1);
  endfunction

  // first requester found scanning upward from the fairness pointer, wrapping at N
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end

  // grant is the owner while locked, else the scan winner; outputs held low during reset
  always_comb begin
    gv = (state_q == LOCKED) || found;
    gid = (state_q == LOCKED) ? owner_q : win;
    grt = (rst_ && gv) ? N'(1) << gid : '0;
    grt_id = (rst_ && gv) ? gid : '0;
    fire = |(grt & req) && ready;
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    if (tmo) begin
      state_d = IDLE;
      ptr_d = inc_mod(owner_q);
    end else if (fire) begin
      state_d = tail[gid] ? IDLE : LOCKED;
      ptr_d = tail[gid] ? inc_mod(gid) : ptr_q;
      owner_d = gid;
    end
  end

  assign busy = (state_q == LOCKED);

  // arbitration state registers
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
    end
  end

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_err_q;

  assign tmo = (state_q == LOCKED) && (cnt_q == CW'(TIMEOUT));
  assign timeout_err = timeout_err_q;

  // stall counter advances on locked cycles without a transfer
  always_comb cnt_d = (tmo || fire) ? '0 : (state_q == LOCKED) ? cnt_q + CW'(1) : '0;

  // stall counter and registered forced-release pulse
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_err_q <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign timeout_err = (TIMEOUT < 0);
`endif
endmodule

// File: tb/tb_arb_rr_lock.sv
// tb_arb_rr_lock: directed and random checks of arb_rr_lock against a packet-level reference model
module tb_arb_rr_lock;
  localparam int N = 5;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] tail = '0;
  logic ready = 1'b0;
  logic [N-1:0] grt;
  logic [2:0] grt_id;
  logic busy, timeout_err;
  int n_cmp = 0;
  int n_err = 0;
  int m_ptr, m_owner, m_cnt;
  bit m_lock, m_terr;

  always #5 clk = ~clk;

  arb_rr_lock #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_(rst_), .req(req), .tail(tail), .ready(ready),
    .grt(grt), .grt_id(grt_id), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr = 0; m_owner = 0; m_lock = 0; m_cnt = 0; m_terr = 0;
  endtask

  function automatic int m_id();
    int j;
    if (m_lock) return m_owner;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (req[3'(j)]) return j;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] t, input logic rd);
    int id;
    req = r; tail = t; ready = rd;
    #1;
    id = m_id();
    chk("grt", 32'(grt), (id < 0) ? 32'd0 : (32'd1 << id));
    chk("grt_id", 32'(grt_id), (id < 0) ? 32'd0 : 32'(id));
    chk("busy", 32'(busy), 32'(m_lock));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  task automatic tick();
    int id;
    bit fire, tmo;
    @(posedge clk);
    id = m_id();
    fire = (id >= 0) && req[3'(id)] && ready;
    tmo = 0;
`ifdef ARB_LOCK_TIMEOUT_EN
    tmo = m_lock && (m_cnt == TO);
    m_terr = tmo;
    if (tmo) begin
      m_lock = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
    end else m_cnt = fire ? 0 : (m_lock ? m_cnt + 1 : 0);
`endif
    if (!tmo && fire) begin
      if (tail[3'(id)]) begin m_lock = 0; m_ptr = (id + 1) % N; end
      else begin m_lock = 1; m_owner = id; end
    end
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    req = 5'b11111; ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grt", 32'(grt), 32'h0);
    chk("rst_grt_id", 32'(grt_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'h0);
    rst_ = 1'b1;
    drive(5'b10100, 5'b11111, 1'b1);
    chk("tp1_c0_grt", 32'(grt), 32'h04);
    chk("tp1_c0_id", 32'(grt_id), 32'd2);
    tick();
    drive(5'b10100, 5'b11111, 1'b1);
    chk("tp1_c1_grt", 32'(grt), 32'h10);
    chk("tp1_c1_id", 32'(grt_id), 32'd4);
    tick();
    drive(5'b10101, 5'b11111, 1'b0);
    chk("tp1_wrap", 32'(grt), 32'h01);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(5'b11111, 5'b11111, 1'b1);
      chk("rotation", 32'(grt_id), 32'(i % 5));
      tick();
    end
    drive(5'b01010, 5'b00000, 1'b1);
    chk("pkt_f1", 32'(grt), 32'h02);
    tick();
    drive(5'b01010, 5'b00000, 1'b1);
    chk("pkt_f2", 32'(grt), 32'h02);
    chk("pkt_f2_busy", 32'(busy), 32'h1);
    tick();
    drive(5'b01010, 5'b00010, 1'b1);
    chk("pkt_f3", 32'(grt), 32'h02);
    chk("pkt_f3_busy", 32'(busy), 32'h1);
    tick();
    drive(5'b01000, 5'b11111, 1'b1);
    chk("pkt_after", 32'(grt), 32'h08);
    chk("pkt_after_busy", 32'(busy), 32'h0);
    tick();
    drive(5'b00100, 5'b00000, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(5'b11111, 5'b00000, 1'b0);
      chk("stall_hold", 32'(grt), 32'h04);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(5'b11011, 5'b00000, 1'b1);
      chk("bubble_hold", 32'(grt), 32'h04);
      tick();
    end
    drive(5'b00100, 5'b00100, 1'b1);
    chk("resume", 32'(grt), 32'h04);
    tick();
    drive(5'b00010, 5'b00000, 1'b1);
    tick();
    drive(5'b11111, 5'b00000, 1'b0);
    #1 rst_ = 1'b0;
    #1;
    chk("async_rst_grt", 32'(grt), 32'h0);
    chk("async_rst_id", 32'(grt_id), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    m_reset();
    @(negedge clk);
    rst_ = 1'b1;
    drive(5'b00001, 5'b11111, 1'b1);
    chk("post_rst", 32'(grt), 32'h01);
    tick();
    drive(5'b01000, 5'b00000, 1'b1);
    tick();
`ifdef ARB_LOCK_TIMEOUT_EN
    for (int i = 0; i <= TO; i++) begin
      drive(5'b11111, 5'b00000, 1'b0);
      chk("to_hold", 32'(grt), 32'h08);
      tick();
    end
    drive(5'b11111, 5'b00000, 1'b0);
    chk("to_pulse", 32'(timeout_err), 32'h1);
    chk("to_busy", 32'(busy), 32'h0);
    chk("to_next", 32'(grt), 32'h10);
    tick();
`else
    for (int i = 0; i < 100; i++) begin
      drive(5'b11111, 5'b00000, 1'b0);
      chk("persist", 32'(grt), 32'h08);
      tick();
    end
    drive(5'b01000, 5'b01000, 1'b1);
    tick();
`endif
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom), 5'($urandom), $urandom_range(0, 3) != 0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
